// File: rtl/gate_sequencer.sv
// gate_sequencer: sequences the entry barrier through open, hold and close
// phases once entry is permitted. Travel is timed (no limit switches); a
// position counter tracks travel so an obstacle while closing reverses the
// gate from wherever it currently is.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   enable_in    entry permitted (level, synchronous)
//   pass_sensor  1 = vehicle under the gate (debounced, synchronous)
//   motor_out    00 stop, 01 open, 10 close (11 never driven)
//   gate_open    1 while in OPEN
//   busy         1 whenever not CLOSED
//   car_passed   one-cycle pulse per vehicle departure from under the gate
//   state_out    current state encoding (CLOSED=0 OPENING=1 OPEN=2 CLOSING=3)
module gate_sequencer #(
    parameter int unsigned TRAVEL_CYCLES = 50,
    parameter int unsigned HOLD_CYCLES   = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_in,
    input  logic       pass_sensor,
    output logic [1:0] motor_out,
    output logic       gate_open,
    output logic       busy,
    output logic       car_passed,
    output logic [2:0] state_out
);

    localparam int unsigned PW = $clog2(TRAVEL_CYCLES + 1);
    localparam int unsigned HW = $clog2(HOLD_CYCLES);

    localparam logic [PW-1:0] POS_FULL  = PW'(TRAVEL_CYCLES);
    localparam logic [PW-1:0] POS_LAST  = PW'(TRAVEL_CYCLES - 1);
    localparam logic [PW-1:0] POS_ONE   = PW'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'd0,
        ST_OPENING = 2'd1,
        ST_OPEN    = 2'd2,
        ST_CLOSING = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          sens_q, sens_d;
    logic          car_passed_q, car_passed_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_CLOSED;
            pos_q        <= '0;
            hold_q       <= '0;
            sens_q       <= 1'b0;
            car_passed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            hold_q       <= hold_d;
            sens_q       <= sens_d;
            car_passed_q <= car_passed_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        hold_d       = hold_q;
        sens_d       = pass_sensor;
        // Departure = sensor falling edge while the gate is anywhere but shut.
        car_passed_d = sens_q & ~pass_sensor & (state_q != ST_CLOSED);

        unique case (state_q)
            ST_CLOSED: begin
                if (enable_in) begin
                    state_d = ST_OPENING;
                end
            end
            ST_OPENING: begin
                // ">=" also covers a reversal on the very first closing cycle,
                // where pos is still at full travel; pos then never exceeds it.
                if (pos_q >= POS_LAST) begin
                    state_d = ST_OPEN;
                    pos_d   = POS_FULL;
                    hold_d  = '0;
                end else begin
                    pos_d = pos_q + 1'b1;
                end
            end
            ST_OPEN: begin
                if (pass_sensor) begin
                    hold_d = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = ST_CLOSING;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_CLOSING: begin
                // Obstacle wins over reaching the closed position; pos holds.
                if (pass_sensor) begin
                    state_d = ST_OPENING;
                end else if (pos_q <= POS_ONE) begin
                    state_d = ST_CLOSED;
                    pos_d   = '0;
                end else begin
                    pos_d = pos_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_CLOSED;
            end
        endcase
    end

    always_comb begin
        motor_out = 2'b00;
        unique case (state_q)
            ST_OPENING: motor_out = 2'b01;
            ST_CLOSING: motor_out = 2'b10;
            default:    motor_out = 2'b00;
        endcase
    end

    assign gate_open  = (state_q == ST_OPEN);
    assign busy       = (state_q != ST_CLOSED);
    assign state_out  = {1'b0, state_q};
    assign car_passed = car_passed_q;

endmodule

// File: tb/tb_gate_sequencer.sv
module tb_gate_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable_in;
    logic       pass_sensor;
    logic [1:0] motor_out;
    logic       gate_open;
    logic       busy;
    logic       car_passed;
    logic [2:0] state_out;

    int total = 0;
    int bad   = 0;
    logic seen_11 = 1'b0;

    always #5 clk = ~clk;

    gate_sequencer #(
        .TRAVEL_CYCLES(4),
        .HOLD_CYCLES  (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable_in  (enable_in),
        .pass_sensor(pass_sensor),
        .motor_out  (motor_out),
        .gate_open  (gate_open),
        .busy       (busy),
        .car_passed (car_passed),
        .state_out  (state_out)
    );

    always @(negedge clk) begin
        if (motor_out == 2'b11) seen_11 = 1'b1;
    end

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       sens;
        logic [2:0] st;
        logic       cp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic s,
                       input logic [2:0] st, input logic cp, input int n);
        for (int i = 0; i < n; i++) vecs.push_back('{r, e, s, st, cp});
    endtask

    // Expected packed outputs {state_out, motor_out, gate_open, busy, car_passed}
    function automatic logic [7:0] expect_of(input logic [2:0] st, input logic cp);
        logic [1:0] m;
        case (st)
            3'd1:    m = 2'b01;
            3'd3:    m = 2'b10;
            default: m = 2'b00;
        endcase
        return {st, m, (st == 3'd2), (st != 3'd0), cp};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int cnt;
        int pulses;

        rst_n = 1'b0; enable_in = 1'b0; pass_sensor = 1'b0;

        // r, e, s, expected state, expected car_passed, repeat
        add(0, 0, 0, 0, 0, 1);   // reset
        add(1, 1, 0, 1, 0, 1);   // enable pulse -> OPENING pos0
        add(1, 0, 0, 1, 0, 3);   // pos 1..3
        add(1, 0, 0, 2, 0, 6);   // OPEN, hold 0..5
        add(1, 0, 0, 3, 0, 4);   // CLOSING pos 4..1
        add(1, 0, 0, 0, 0, 2);   // CLOSED
        add(1, 1, 0, 1, 0, 1);   // reopen
        add(1, 0, 0, 1, 0, 3);
        add(1, 0, 0, 2, 0, 3);   // OPEN hold 0,1,2
        add(1, 0, 1, 2, 0, 3);   // car under gate, hold cleared
        add(1, 0, 0, 2, 1, 1);   // departure pulse, hold 1
        add(1, 0, 0, 2, 0, 4);   // hold 2..5
        add(1, 0, 0, 3, 0, 3);   // CLOSING pos 4,3,2
        add(1, 0, 1, 1, 0, 1);   // obstacle at pos2 -> OPENING, pos holds
        add(1, 0, 0, 1, 1, 1);   // pos3, car leaves during reopen
        add(1, 0, 0, 2, 0, 6);   // OPEN
        add(1, 0, 0, 3, 0, 4);   // CLOSING pos 4..1
        add(1, 0, 1, 1, 0, 2);   // obstacle at pos1 beats closing; pos 1,2
        add(1, 0, 0, 1, 1, 1);   // pos3
        add(1, 0, 0, 2, 0, 1);   // OPEN after 3 open cycles
        add(0, 0, 0, 0, 0, 1);   // reset from OPEN
        add(1, 0, 1, 0, 0, 1);   // sensor toggle in CLOSED: ignored
        add(1, 0, 0, 0, 0, 2);
        add(1, 1, 0, 1, 0, 1);
        add(1, 0, 0, 1, 0, 2);   // OPENING pos 1,2
        add(0, 0, 0, 0, 0, 1);   // reset mid-travel
        add(1, 1, 0, 1, 0, 4);   // enable held: 4 full open cycles
        add(1, 1, 0, 2, 0, 6);
        add(1, 1, 0, 3, 0, 4);
        add(1, 1, 0, 0, 0, 1);   // one cycle CLOSED
        add(1, 1, 0, 1, 0, 1);   // reopens immediately

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n       = vecs[i].rst_n;
            enable_in   = vecs[i].en;
            pass_sensor = vecs[i].sens;
            tick();
            check($sformatf("vec%0d", i),
                  {24'd0, state_out, motor_out, gate_open, busy, car_passed},
                  {24'd0, expect_of(vecs[i].st, vecs[i].cp)});
        end

        // Hand sequence: full open length from closed, measured directly.
        rst_n = 1'b0; enable_in = 1'b0; pass_sensor = 1'b0;
        tick();
        rst_n = 1'b1; enable_in = 1'b1;
        tick();
        enable_in = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20 && motor_out == 2'b01; i++) begin
            cnt++;
            tick();
        end
        check("open_len", cnt, 4);
        check("open_reached", {31'd0, gate_open}, 1);

        // Hand sequence: long sensor assertion yields exactly one pulse,
        // then the gate closes fully.
        pass_sensor = 1'b1;
        repeat (10) tick();
        pass_sensor = 1'b0;
        pulses = 0;
        repeat (12) begin
            tick();
            if (car_passed) pulses++;
        end
        check("long_sensor_pulses", pulses, 1);
        check("closed_after_hold", {29'd0, state_out}, 0);
        check("idle_after_close", {31'd0, busy}, 0);

        check("motor_never_11", {31'd0, seen_11}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
